// File: rtl/mem_access_pkg.sv
// ============================================================================
//  Module   : mem_access_pkg
//  Purpose  : Shared types and constants for the data-memory access controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam int ADDR_W_DEFAULT = 12;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Size 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
//  Module   : mem_access_ctrl_if
//  Purpose  : Request/response handshake plus memory-side bus of the controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_din;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_dout;

    // Master is the requester together with the memory it talks to.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we, mem_re
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_din, mem_we, mem_re
    );
endinterface

`default_nettype wire

// File: rtl/mem_lane_fmt.sv
// ============================================================================
//  Module   : mem_lane_fmt
//  Purpose  : Little-endian lane extraction/extension for loads and lane merge
//             for sub-word stores (read-modify-write data path).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [31:0] i_wdata,
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    input  wire logic [1:0]  i_addr_lo,
    output logic      [31:0] o_load,
    output logic      [31:0] o_merged
);
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = {i_addr_lo, 3'b000};
    assign w_byte  = i_word[w_shift +: 8];
    assign w_half  = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load                = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_merged              = i_word;
                o_merged[w_shift +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load   = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_merged = i_addr_lo[1] ? {i_wdata[15:0], i_word[15:0]}
                                        : {i_word[31:16], i_wdata[15:0]};
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : Single-outstanding load/store initiator for the word-organised
//             data memory; sub-word stores are done as read-modify-write.
//             Optional macro ADDR_ALIGN_CHECK_EN enables misalignment errors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
)(
    input  wire logic        clk,
    input  wire logic        rst,
    mem_access_ctrl_if.slave bus
);
    state_e            r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_mem_we;
    logic              r_mem_re;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [31:0]       r_mem_din;
    logic              r_we;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [1:0]        r_addr_lo;

    logic        w_accept;
    logic        w_misalign;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic        w_unused_addr;

    assign w_accept      = bus.req_valid && r_req_ready;
    assign w_unused_addr = ^bus.req_addr[31:ADDR_W];

`ifdef ADDR_ALIGN_CHECK_EN
    logic r_resp_err;
    assign w_misalign   = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign bus.resp_err = r_resp_err;
`else
    assign w_misalign   = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // r_mem_din doubles as the latched store data until the merge in CAPT.
    mem_lane_fmt u_fmt (
        .i_word     (bus.mem_dout),
        .i_wdata    (r_mem_din),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_addr_lo  (r_addr_lo),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= SZ_BYTE;
            r_addr_lo    <= 2'b00;
`ifdef ADDR_ALIGN_CHECK_EN
            r_resp_err   <= 1'b0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_we         <= bus.req_we;
                        r_uns        <= bus.req_unsigned;
                        r_size       <= bus.req_size;
                        r_addr_lo    <= bus.req_addr[1:0];
                        r_mem_addr   <= bus.req_addr[ADDR_W-1:2];
                        r_mem_din    <= bus.req_wdata;
                        r_resp_rdata <= '0;
                        if (w_misalign) begin
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
`ifdef ADDR_ALIGN_CHECK_EN
                            r_resp_err   <= 1'b1;
`endif
                        end else if (bus.req_we && is_word(bus.req_size)) begin
                            r_state  <= ST_WRITE;
                            r_mem_we <= 1'b1;
                        end else begin
                            r_state  <= ST_READ;
                            r_mem_re <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_mem_re <= 1'b0;
                    r_state  <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (r_we) begin
                        r_mem_din <= w_merged;
                        r_mem_we  <= 1'b1;
                        r_state   <= ST_WRITE;
                    end else begin
                        r_resp_rdata <= w_load;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    r_req_ready  <= 1'b1;
                    r_resp_rdata <= '0;
                    r_mem_addr   <= '0;
                    r_mem_din    <= '0;
`ifdef ADDR_ALIGN_CHECK_EN
                    r_resp_err   <= 1'b0;
`endif
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_re    <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_re     = r_mem_re;
endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench for mem_access_ctrl against a byte-array
//             model of the memory. Honours ADDR_ALIGN_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus();
    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Word memory with registered read, plus a preload port for setup.
    logic [31:0] dev_mem [1024];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_en) dev_mem[ld_addr] <= ld_data;
        else if (bus.mem_we) dev_mem[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_re) bus.mem_dout <= dev_mem[bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          mon_re = 0, mon_we = 0, mon_ov = 0, mon_resp = 0;
    int          last_re_cyc = 0, last_we_cyc = 0;
    logic [31:0] last_we_din = '0;
    always @(negedge clk) begin
        if (bus.mem_re) begin mon_re <= mon_re + 1; last_re_cyc <= cyc; end
        if (bus.mem_we) begin mon_we <= mon_we + 1; last_we_cyc <= cyc; last_we_din <= bus.mem_din; end
        if (bus.mem_re && bus.mem_we) mon_ov <= mon_ov + 1;
        if (bus.resp_valid) mon_resp <= mon_resp + 1;
    end

    // Reference: flat little-endian byte array.
    byte unsigned rmem [4096];
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          timeout;
        int          acc_cyc;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          re_n;
        int          we_n;
        int          ov_n;
        int          re_lat;
        int          we_lat;
        logic [31:0] we_din;
    } obs_t;

    function automatic int base_of(input logic [31:0] addr, input logic [1:0] sz);
        int a;
        a = int'(addr[11:0]);
        if (sz == SZ_BYTE) return a;
        if (sz == SZ_HALF) return a - (a % 2);
        return a - (a % 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
        int     a;
        longint v;
        a = base_of(addr, sz);
        if (sz == SZ_BYTE) begin
            v = longint'(rmem[a]);
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == SZ_HALF) begin
            v = longint'(rmem[a]) + 256 * longint'(rmem[a+1]);
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(rmem[a]) + 256 * longint'(rmem[a+1]) + 65536 * longint'(rmem[a+2])
              + 16777216 * longint'(rmem[a+3]);
        end
        return v[31:0];
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] addr, input logic [1:0] sz);
`ifdef ADDR_ALIGN_CHECK_EN
        int a;
        a = int'(addr[11:0]);
        return (sz == SZ_HALF && (a % 2) != 0) || (sz >= SZ_WORD && (a % 4) != 0);
`else
        return (addr[31] && !addr[31]);
`endif
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        int a, n;
        a = base_of(addr, sz);
        n = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
        for (int i = 0; i < n; i++) rmem[a+i] = wd[8*i +: 8];
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, output obs_t o);
        int re0, we0, ov0, n;
        o = '{default: 0};
        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.req_ready) begin o.timeout = 1; bus.req_valid = 1'b0; return; end
        o.acc_cyc = cyc; re0 = mon_re; we0 = mon_we; ov0 = mon_ov;
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.resp_valid) begin o.timeout = 1; return; end
        o.lat    = cyc - o.acc_cyc;
        o.rdata  = bus.resp_rdata;
        o.err    = bus.resp_err;
        o.re_n   = mon_re - re0;
        o.we_n   = mon_we - we0;
        o.ov_n   = mon_ov - ov0;
        o.re_lat = last_re_cyc - o.acc_cyc;
        o.we_lat = last_we_cyc - o.acc_cyc;
        o.we_din = last_we_din;
    endtask

    task automatic preload();
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = (i == 4) ? 32'h8899AABB : $urandom;
            ld_en = 1'b1; ld_addr = 10'(i); ld_data = w;
            for (int b = 0; b < 4; b++) rmem[4*i+b] = w[8*b +: 8];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if ({bus.mem_we, bus.mem_re} !== 2'b00) begin failures++; $display("FAIL rst_we_re got=%b exp=00", {bus.mem_we, bus.mem_re}); end
        checks++; if (bus.mem_addr !== '0 || bus.mem_din !== '0) begin failures++; $display("FAIL rst_addr_din got=%h/%h exp=0/0", bus.mem_addr, bus.mem_din); end
        checks++; if (bus.resp_rdata !== '0 || bus.resp_err !== 1'b0) begin failures++; $display("FAIL rst_rdata_err got=%h/%b exp=0/0", bus.resp_rdata, bus.resp_err); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_loads();
        logic [31:0] ad [5] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10};
        logic [1:0]  sz [5] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF};
        logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ex [5] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFFFBB, 32'hFFFF8899, 32'h0000AABB};
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], $urandom, 1'b0, o);
            checks++; if (o.timeout != 0) begin failures++; $display("FAIL load_timeout i=%0d", i); end
            checks++; if (o.rdata !== ex[i] || o.rdata !== ref_load(ad[i], sz[i], un[i])) begin
                failures++; $display("FAIL load_rdata i=%0d got=%h exp=%h", i, o.rdata, ex[i]); end
            checks++; if (o.lat != 3) begin failures++; $display("FAIL load_latency i=%0d got=%0d exp=3", i, o.lat); end
            checks++; if (o.re_n != 1 || o.re_lat != 1 || o.we_n != 0) begin
                failures++; $display("FAIL load_mem_ctl i=%0d re_n=%0d re_lat=%0d we_n=%0d exp=1/1/0", i, o.re_n, o.re_lat, o.we_n); end
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 1'b0, o);
        checks++; if (o.timeout != 0) begin failures++; $display("FAIL mis_timeout"); end
`ifdef ADDR_ALIGN_CHECK_EN
        checks++; if (o.lat != 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.re_n != 0) begin
            failures++; $display("FAIL mis_resp lat=%0d err=%b rdata=%h re_n=%0d exp=1/1/0/0", o.lat, o.err, o.rdata, o.re_n); end
`else
        checks++; if (o.lat != 3 || o.err !== 1'b0 || o.rdata !== 32'h8899AABB) begin
            failures++; $display("FAIL mis_resp lat=%0d err=%b rdata=%h exp=3/0/8899aabb", o.lat, o.err, o.rdata); end
`endif
    endtask

    task automatic test_reset_abort();
        int   n, we0, resp0;
        obs_t o;
        bus.req_we = 1'b1; bus.req_size = SZ_HALF; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0000CAFE; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (!bus.req_ready) begin failures++; $display("FAIL abort_accept_timeout"); end
        we0 = mon_we; resp0 = mon_resp;
        @(posedge clk); #1;          // READ
        bus.req_valid = 1'b0;
        @(posedge clk); #1;          // CAPT
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (mon_we != we0) begin failures++; $display("FAIL abort_we got=%0d exp=0", mon_we - we0); end
        checks++; if (mon_resp != resp0) begin failures++; $display("FAIL abort_resp got=%0d exp=0", mon_resp - resp0); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, o);
        checks++; if (o.timeout != 0 || o.rdata !== 32'h8899AABB) begin
            failures++; $display("FAIL abort_readback got=%h exp=8899aabb", o.rdata); end
    endtask

    task automatic test_byte_store();
        obs_t o;
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234565A, 1'b0, o);
        ref_store(32'h11, SZ_BYTE, 32'h1234565A);
        checks++; if (o.timeout != 0 || o.lat != 4) begin failures++; $display("FAIL sb_latency got=%0d exp=4", o.lat); end
        checks++; if (o.re_n != 1 || o.re_lat != 1) begin failures++; $display("FAIL sb_re re_n=%0d re_lat=%0d exp=1/1", o.re_n, o.re_lat); end
        checks++; if (o.we_n != 1 || o.we_lat != 3) begin failures++; $display("FAIL sb_we we_n=%0d we_lat=%0d exp=1/3", o.we_n, o.we_lat); end
        checks++; if (o.we_din !== 32'h88995ABB) begin failures++; $display("FAIL sb_din got=%h exp=88995abb", o.we_din); end
        checks++; if (o.rdata !== 32'h0) begin failures++; $display("FAIL sb_rdata got=%h exp=0", o.rdata); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, o);
        checks++; if (o.rdata !== 32'h88995ABB || o.rdata !== ref_load(32'h10, SZ_WORD, 1'b0)) begin
            failures++; $display("FAIL sb_readback got=%h exp=88995abb", o.rdata); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h14, 32'hDEADBEEF, 1'b1, o1);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 1'b0, o2);
        ref_store(32'h14, SZ_WORD, 32'hDEADBEEF);
        checks++; if (o1.timeout != 0 || o1.lat != 2 || o1.we_din !== 32'hDEADBEEF || o1.re_n != 0) begin
            failures++; $display("FAIL b2b_sw lat=%0d din=%h re_n=%0d exp=2/deadbeef/0", o1.lat, o1.we_din, o1.re_n); end
        checks++; if (o2.acc_cyc != o1.acc_cyc + o1.lat + 1) begin
            failures++; $display("FAIL b2b_accept got=%0d exp=%0d", o2.acc_cyc, o1.acc_cyc + o1.lat + 1); end
        checks++; if (o2.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_lw got=%h exp=deadbeef", o2.rdata); end
        checks++; if (o1.ov_n + o2.ov_n != 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", o1.ov_n + o2.ov_n); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] addr, wd, exp_rd;
        bit          mis, hold;
        int          exp_lat, exp_re;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
            addr = $urandom; wd = $urandom;
            hold = (i < 79) ? 1'($urandom) : 1'b0;
            mis = ref_misaligned(addr, sz);
            exp_rd  = (mis || we) ? 32'h0 : ref_load(addr, sz, uns);
            exp_lat = mis ? 1 : !we ? 3 : (sz >= SZ_WORD) ? 2 : 4;
            exp_re  = (mis || (we && sz >= SZ_WORD)) ? 0 : 1;
            do_req(we, sz, uns, addr, wd, hold, o);
            if (we && !mis) ref_store(addr, sz, wd);
            checks++; if (o.timeout != 0) begin failures++; $display("FAIL rand_timeout i=%0d", i); end
            checks++; if (o.rdata !== exp_rd || o.err !== logic'(mis)) begin
                failures++; $display("FAIL rand_resp i=%0d rdata=%h err=%b exp=%h/%b", i, o.rdata, o.err, exp_rd, mis); end
            checks++; if (o.lat != exp_lat) begin failures++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, o.lat, exp_lat); end
            checks++; if (o.re_n != exp_re || o.we_n != int'(we && !mis)) begin
                failures++; $display("FAIL rand_mem_ctl i=%0d re_n=%0d we_n=%0d exp=%0d/%0d", i, o.re_n, o.we_n, exp_re, int'(we && !mis)); end
            if (we && !mis) begin
                checks++; if (o.we_din !== ref_load(addr, SZ_WORD, 1'b0)) begin
                    failures++; $display("FAIL rand_din i=%0d got=%h exp=%h", i, o.we_din, ref_load(addr, SZ_WORD, 1'b0)); end
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (mon_ov != 0) begin failures++; $display("FAIL rand_overlap got=%0d exp=0", mon_ov); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        @(posedge clk); #1;
        preload();
        test_reset();
        test_loads();
        test_misalign();
        test_reset_abort();
        test_byte_store();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
